acc_pipe_core: RTL and testbench
================================

# acc_pipe_core

Parametrised 3-stage pipelined accumulator processor core: the next generation of the team's 16-bit accumulator CPU datapath. Data width, address width and data memory depth are configurable. The core adds several behaviours the previous datapath lacked:
- an explicit run/idle control FSM,
- store-to-load forwarding,
- branch flushing,
- a host load port for data memory.

It sits between an external combinational instruction ROM and the system bench/top, and replaces the datapath plus hazard unit pair.

## Interface
- `W`, 16: data/accumulator width (≥4).
- `A`, 13: address width for both PC and data address. Instruction width is IW = 3+A (opcode in [IW-1:A], operand in [A-1:0]).
- `DEPTH`, 2**A: data memory words. Addresses ≥ DEPTH read 0 and ignore writes.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins execution at PC 0 when idle.
- `stop`  in  1  pulse; returns to idle, pipeline flushed.
- `imem_addr`  out  A  fetch address (= PC).
- `imem_data`  in  IW  instruction at imem_addr, same cycle.
- `host_we`  in  1  data memory write strobe; honoured only when idle.
- `host_addr`  in  A  host write address.
- `host_wdata`  in  W  host write data.
- `acc`  out  W  accumulator value.
- `acc_zero`  out  1  acc == 0.
- `busy`  out  1  high in RUN.
- `retire`  out  1  one-cycle pulse per instruction completing E.

## Operation
- Opcodes:
  - 000 LOAD: acc = M[a]
  - 001 STORE: M[a] = acc
  - 010 ADD: acc = acc + M[a], mod 2^W
  - 011 MUL: acc = low W bits of acc*M[a]
  - 100 AND: acc = acc & M[a]
  - 101 NOT: acc = ~acc, operand ignored
  - 110 JZ: if acc == 0 then PC = a
  - 111 JMP: PC = a
- FSM states:
  - IDLE --start--> RUN. Entering RUN loads PC = 0 and invalidates D and E.
  - RUN --stop--> IDLE. Stop takes priority over a same-cycle branch or retire; no state changes that cycle except PC/valids.
  - start while RUN is ignored; stop while IDLE is ignored.
- Pipeline stages:
  - F: PC drives imem_addr; instruction latched into D register with a valid bit. PC += 1, wrapping 2^A-1 → 0.
  - D: data memory read of M[operand], registered into E operand register along with the instruction and valid bit.
  - E: ALU/acc update, STORE write, branch resolve, retire pulse.
- Forwarding: if E holds a valid STORE to address x and D reads x in the same cycle, the E operand register captures the store data (acc), not the stale array word.
- Accumulator hazards: none. The single acc is read and written only in E, in order.
- Taken branch in E: PC = a; D and E valid bits cleared (2 bubble cycles). JZ tests the acc value present at E. Not-taken JZ costs no bubble.
- Host writes take effect at the clock edge when IDLE and host_we=1. They are dropped in RUN.
- Reset values: PC 0, acc 0, all valids 0, state IDLE, busy 0, retire 0, acc_zero 1. Data memory contents are not reset.

## Timing
- Start sampled at edge N: busy=1 after N. Instruction at 0 is fetched in cycle N+1, enters E in cycle N+3, and retire rises after edge N+3 (retire is registered).
- Throughput: 1 instruction/cycle. A taken branch costs 2 cycles; first target retire is 3 cycles after the branch retire.
- Acc updated at the edge ending E; acc_zero is combinational from acc.
- Stop at edge M: busy=0 after M; no retire after M. An instruction in E at edge M does not commit.
- Reset asserted mid-run: all state returns to reset values immediately (async), without waiting for a clock edge.

## Structure
- Shared package `acc_pipe_pkg`: opcode localparams (OP_LOAD…OP_JMP) and FSM state encoding (ST_IDLE, ST_RUN).
- One sub-module `acc_pipe_alu`: combinational, parametrised on W; inputs op, acc, operand; outputs next acc.
- Data memory is an inferred register array inside the core.

## Test plan
- Reset/idle: deassert reset, W=16 → acc=0, acc_zero=1, busy=0, imem_addr=0. Start → retire first rises exactly 3 cycles later.
- Arithmetic: host-load M[1]=7, M[2]=5; program LOAD 1, ADD 2, MUL 2, NOT → acc 7, 12, 60, 0xFFC3. ADD of 0xFFFF+1 wraps to 0.
- Forwarding: LOAD 1 (M[1]=3), STORE 4, LOAD 4 back-to-back → acc=3. Run again with forwarding suppressed by program spacing → same result.
- Branch: LOAD 0 (M[0]=0), JZ 8, two ADD fillers, ADD at 8 → fillers never retire. Gap of 2 cycles on retire. JZ with acc≠0 falls through with no gap.
- Stop/restart and host gating: host_we during RUN to M[3]=9 → M[3] unchanged. Stop mid-program → busy 0 next cycle, acc frozen. Start again → PC restarts at 0.
- Async reset mid-run: assert reset between edges → busy, retire, acc all 0 before next edge. PC wrap test with A=3: sequential code at 7 continues at 0.

Source files
------------

// File: rtl/acc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// acc_pipe_pkg
// Shared definitions for the acc_pipe accumulator core:
//   - 3-bit opcode encodings (OP_LOAD .. OP_JMP)
//   - run/idle control FSM state encoding (state_t)
// No ports; imported by the core, the ALU and the bus interface users.
// ---------------------------------------------------------------------------
package acc_pipe_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_JMP   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_pipe_core_if.sv
// ---------------------------------------------------------------------------
// acc_pipe_core_if
// Bundles the control, instruction-fetch, host-load and status signals of
// acc_pipe_core.
//   master : the system side (drives start/stop, instruction data, host writes)
//   slave  : the core (drives fetch address, acc, acc_zero, busy, retire)
// Parameters W (data width) and A (address width) must match the core.
// ---------------------------------------------------------------------------
interface acc_pipe_core_if #(
    parameter int W = 16,
    parameter int A = 13
);
    localparam int IW = 3 + A;

    logic          start;
    logic          stop;
    logic [A-1:0]  imem_addr;
    logic [IW-1:0] imem_data;
    logic          host_we;
    logic [A-1:0]  host_addr;
    logic [W-1:0]  host_wdata;
    logic [W-1:0]  acc;
    logic          acc_zero;
    logic          busy;
    logic          retire;

    modport master (
        output start, stop, imem_data, host_we, host_addr, host_wdata,
        input  imem_addr, acc, acc_zero, busy, retire
    );

    modport slave (
        input  start, stop, imem_data, host_we, host_addr, host_wdata,
        output imem_addr, acc, acc_zero, busy, retire
    );

endinterface

// File: rtl/acc_pipe_alu.sv
// ---------------------------------------------------------------------------
// acc_pipe_alu
// Combinational accumulator ALU.
//   op_i      : 3-bit opcode of the instruction in E
//   acc_i     : current accumulator
//   operand_i : memory operand captured for E
//   acc_o     : next accumulator; equals acc_i for STORE/JZ/JMP
// Arithmetic is modulo 2^W (ADD and MUL keep the low W bits).
// ---------------------------------------------------------------------------
module acc_pipe_alu
    import acc_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] operand_i,
    output logic [W-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        case (op_i)
            OP_LOAD: acc_o = operand_i;
            OP_ADD:  acc_o = acc_i + operand_i;
            OP_MUL:  acc_o = acc_i * operand_i;
            OP_AND:  acc_o = acc_i & operand_i;
            OP_NOT:  acc_o = ~acc_i;
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/acc_pipe_core.sv
// ---------------------------------------------------------------------------
// acc_pipe_core
// 3-stage (F/D/E) pipelined accumulator processor with run/idle control,
// store-to-load forwarding, branch flushing and a host load port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : acc_pipe_core_if.slave
//           start/stop pulses, imem_addr/imem_data fetch port,
//           host_we/host_addr/host_wdata data-memory load port (idle only),
//           acc/acc_zero/busy/retire status
// Data memory is an internal array of DEPTH words; addresses >= DEPTH read 0
// and ignore writes. Memory contents are not reset.
// ---------------------------------------------------------------------------
module acc_pipe_core
    import acc_pipe_pkg::*;
#(
    parameter int W     = 16,
    parameter int A     = 13,
    parameter int DEPTH = 2**A
) (
    input  logic           clk,
    input  logic           reset,
    acc_pipe_core_if.slave bus
);

    localparam int IW = 3 + A;

    state_t        state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic          d_valid_q, d_valid_d;
    logic [IW-1:0] d_instr_q, d_instr_d;
    logic          e_valid_q, e_valid_d;
    logic [IW-1:0] e_instr_q, e_instr_d;
    logic [W-1:0]  e_opnd_q, e_opnd_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          retire_q, retire_d;

    logic [W-1:0]  mem [DEPTH];
    logic          mem_we;
    logic [A-1:0]  mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    logic [2:0]    e_op;
    logic [A-1:0]  e_addr;
    logic [A-1:0]  d_addr;
    logic [W-1:0]  alu_acc;
    logic          fwd_store;
    logic          branch_taken;

    function automatic logic in_range(input logic [A-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    assign e_op   = e_instr_q[IW-1:A];
    assign e_addr = e_instr_q[A-1:0];
    assign d_addr = d_instr_q[A-1:0];

    assign mem_rdata = in_range(d_addr) ? mem[d_addr] : '0;

    // The store in E writes the array at the same edge D reads it, so the
    // array word is stale; take the value being stored instead.
    assign fwd_store = e_valid_q && (e_op == OP_STORE) && (e_addr == d_addr);

    // JZ looks at the accumulator as it stands while the JZ is in E.
    assign branch_taken = e_valid_q &&
                          ((e_op == OP_JMP) || ((e_op == OP_JZ) && (acc_q == '0)));

    acc_pipe_alu #(.W(W)) u_alu (
        .op_i      (e_op),
        .acc_i     (acc_q),
        .operand_i (e_opnd_q),
        .acc_o     (alu_acc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        d_valid_d = d_valid_q;
        d_instr_d = d_instr_q;
        e_valid_d = e_valid_q;
        e_instr_d = e_instr_q;
        e_opnd_d  = e_opnd_q;
        acc_d     = acc_q;
        retire_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = e_addr;
        mem_wdata = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.host_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.host_addr;
                    mem_wdata = bus.host_wdata;
                end
                if (bus.start) begin
                    state_d   = ST_RUN;
                    pc_d      = '0;
                    d_valid_d = 1'b0;
                    e_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    // The instruction in E is abandoned: no acc, memory or
                    // retire update on this edge.
                    state_d   = ST_IDLE;
                    d_valid_d = 1'b0;
                    e_valid_d = 1'b0;
                end else begin
                    pc_d      = pc_q + A'(1);
                    d_instr_d = bus.imem_data;
                    d_valid_d = 1'b1;
                    e_instr_d = d_instr_q;
                    e_valid_d = d_valid_q;
                    e_opnd_d  = fwd_store ? acc_q : mem_rdata;
                    if (e_valid_q) begin
                        retire_d = 1'b1;
                        acc_d    = alu_acc;
                        mem_we   = (e_op == OP_STORE);
                    end
                    if (branch_taken) begin
                        pc_d      = e_addr;
                        d_valid_d = 1'b0;
                        e_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
            e_valid_q <= 1'b0;
            e_instr_q <= '0;
            e_opnd_q  <= '0;
            acc_q     <= '0;
            retire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            d_valid_q <= d_valid_d;
            d_instr_q <= d_instr_d;
            e_valid_q <= e_valid_d;
            e_instr_q <= e_instr_d;
            e_opnd_q  <= e_opnd_d;
            acc_q     <= acc_d;
            retire_q  <= retire_d;
        end
    end

    // Plain array write port, kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (reset && mem_we && in_range(mem_waddr)) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.acc       = acc_q;
    assign bus.acc_zero  = (acc_q == '0);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.retire    = retire_q;

endmodule

// File: tb/tb_acc_pipe_core.sv
module tb_acc_pipe_core;
    import acc_pipe_pkg::*;

    localparam int W   = 16;
    localparam int A   = 13;
    localparam int IW  = 3 + A;
    localparam int A2  = 3;
    localparam int IW2 = 3 + A2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    acc_pipe_core_if #(.W(W), .A(A))  bus ();
    acc_pipe_core_if #(.W(W), .A(A2)) bus2 ();

    acc_pipe_core #(.W(W), .A(A))  dut  (.clk(clk), .reset(reset), .bus(bus));
    acc_pipe_core #(.W(W), .A(A2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [IW-1:0]  rom  [2**A];
    logic [IW2-1:0] rom2 [2**A2];
    assign bus.imem_data  = rom[bus.imem_addr];
    assign bus2.imem_data = rom2[bus2.imem_addr];

    int checks = 0;
    int failures = 0;
    int ret_cyc[$];
    logic [W-1:0] ret_acc[$];
    logic busy_after_stop;
    logic [A-1:0] first_addr;

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input int a);
        return {op, a[A-1:0]};
    endfunction

    function automatic int cyc_at(input int i);
        if (i < ret_cyc.size()) return ret_cyc[i];
        return -1;
    endfunction

    function automatic logic [W-1:0] acc_at(input int i);
        if (i < ret_acc.size()) return ret_acc[i];
        return 'x;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 2**A; i++) rom[i] = ins(OP_JMP, i);
    endtask

    task automatic host_write(input int addr, input logic [W-1:0] data);
        bus.host_we    = 1'b1;
        bus.host_addr  = addr[A-1:0];
        bus.host_wdata = data;
        @(negedge clk);
        bus.host_we = 1'b0;
    endtask

    // Pulse start, then watch ncyc negedges; c counts negedges after the
    // start edge. Optional stop at c==stop_at and a host poke at c==1.
    task automatic run_prog(input int ncyc, input int stop_at, input bit poke);
        ret_cyc.delete();
        ret_acc.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        first_addr = bus.imem_addr;
        for (int c = 0; c < ncyc; c++) begin
            if (bus.retire) begin
                ret_cyc.push_back(c);
                ret_acc.push_back(bus.acc);
            end
            if (c == stop_at + 1) busy_after_stop = bus.busy;
            bus.stop       = (c == stop_at);
            bus.host_we    = poke && (c == 1);
            bus.host_addr  = A'(3);
            bus.host_wdata = 16'h0009;
            @(negedge clk);
        end
        bus.host_we = 1'b0;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.acc !== 16'h0000) begin failures++; $display("FAIL reset_acc got %h exp 0000", bus.acc); end
        checks++; if (bus.acc_zero !== 1'b1) begin failures++; $display("FAIL reset_acc_zero got %b exp 1", bus.acc_zero); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.imem_addr !== '0) begin failures++; $display("FAIL reset_imem_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.retire !== 1'b0) begin failures++; $display("FAIL reset_retire got %b exp 0", bus.retire); end
        $display("reset: acc=%h busy=%b", bus.acc, bus.busy);
    endtask

    task automatic test_arith();
        host_write(1, 16'd7);
        host_write(2, 16'd5);
        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        rom[1] = ins(OP_ADD, 2);
        rom[2] = ins(OP_MUL, 2);
        rom[3] = ins(OP_NOT, 0);
        run_prog(10, -10, 1'b0);
        checks++; if (cyc_at(0) !== 3) begin failures++; $display("FAIL first_retire_cycle got %0d exp 3", cyc_at(0)); end
        checks++; if (acc_at(0) !== 16'd7) begin failures++; $display("FAIL arith_load got %h exp 0007", acc_at(0)); end
        checks++; if (acc_at(1) !== 16'd12) begin failures++; $display("FAIL arith_add got %h exp 000c", acc_at(1)); end
        checks++; if (acc_at(2) !== 16'd60) begin failures++; $display("FAIL arith_mul got %h exp 003c", acc_at(2)); end
        checks++; if (acc_at(3) !== 16'hFFC3) begin failures++; $display("FAIL arith_not got %h exp ffc3", acc_at(3)); end
        checks++; if (cyc_at(3) !== 6) begin failures++; $display("FAIL arith_throughput got %0d exp 6", cyc_at(3)); end
        $display("arith: acc seq %h %h %h %h", acc_at(0), acc_at(1), acc_at(2), acc_at(3));

        host_write(5, 16'hFFFF);
        host_write(6, 16'h0001);
        clear_rom();
        rom[0] = ins(OP_LOAD, 5);
        rom[1] = ins(OP_ADD, 6);
        run_prog(8, -10, 1'b0);
        checks++; if (acc_at(1) !== 16'h0000) begin failures++; $display("FAIL add_wrap got %h exp 0000", acc_at(1)); end
        checks++; if (bus.acc_zero !== 1'b1) begin failures++; $display("FAIL add_wrap_zero got %b exp 1", bus.acc_zero); end
        $display("add wrap: acc=%h acc_zero=%b", bus.acc, bus.acc_zero);
    endtask

    task automatic test_forwarding();
        host_write(1, 16'd3);
        host_write(4, 16'h0055);
        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        rom[1] = ins(OP_STORE, 4);
        rom[2] = ins(OP_LOAD, 4);
        run_prog(8, -10, 1'b0);
        checks++; if (acc_at(2) !== 16'd3) begin failures++; $display("FAIL fwd_back_to_back got %h exp 0003", acc_at(2)); end
        $display("forward b2b: acc=%h", acc_at(2));

        host_write(4, 16'h0055);
        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        rom[1] = ins(OP_STORE, 4);
        rom[2] = ins(OP_STORE, 9);
        rom[3] = ins(OP_LOAD, 4);
        run_prog(9, -10, 1'b0);
        checks++; if (acc_at(3) !== 16'd3) begin failures++; $display("FAIL fwd_spaced got %h exp 0003", acc_at(3)); end
        $display("forward spaced: acc=%h", acc_at(3));
    endtask

    task automatic test_branch();
        host_write(0, 16'd0);
        clear_rom();
        rom[0] = ins(OP_LOAD, 0);
        rom[1] = ins(OP_JZ, 8);
        rom[2] = ins(OP_ADD, 2);
        rom[3] = ins(OP_ADD, 2);
        rom[8] = ins(OP_ADD, 2);
        run_prog(10, -10, 1'b0);
        checks++; if (cyc_at(2) !== 7) begin failures++; $display("FAIL jz_taken_gap got %0d exp 7", cyc_at(2)); end
        checks++; if (acc_at(2) !== 16'd5) begin failures++; $display("FAIL jz_taken_acc got %h exp 0005", acc_at(2)); end
        $display("jz taken: target retire cycle=%0d acc=%h", cyc_at(2), acc_at(2));

        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        rom[1] = ins(OP_JZ, 8);
        rom[2] = ins(OP_ADD, 2);
        rom[8] = ins(OP_NOT, 0);
        run_prog(8, -10, 1'b0);
        checks++; if (cyc_at(2) !== 5) begin failures++; $display("FAIL jz_not_taken_cycle got %0d exp 5", cyc_at(2)); end
        checks++; if (acc_at(2) !== 16'd8) begin failures++; $display("FAIL jz_not_taken_acc got %h exp 0008", acc_at(2)); end
        $display("jz not taken: retire cycle=%0d acc=%h", cyc_at(2), acc_at(2));
    endtask

    task automatic test_stop_restart();
        host_write(3, 16'h0011);
        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        for (int i = 1; i < 8; i++) rom[i] = ins(OP_ADD, 2);
        run_prog(10, 5, 1'b1);
        checks++; if (busy_after_stop !== 1'b0) begin failures++; $display("FAIL stop_busy got %b exp 0", busy_after_stop); end
        checks++; if (ret_cyc.size() !== 3) begin failures++; $display("FAIL stop_retire_count got %0d exp 3", ret_cyc.size()); end
        checks++; if (bus.acc !== 16'd13) begin failures++; $display("FAIL stop_acc_frozen got %h exp 000d", bus.acc); end
        $display("stop: retires=%0d acc=%h", ret_cyc.size(), bus.acc);

        clear_rom();
        rom[0] = ins(OP_LOAD, 3);
        run_prog(6, -10, 1'b0);
        checks++; if (first_addr !== '0) begin failures++; $display("FAIL restart_pc got %h exp 0", first_addr); end
        checks++; if (acc_at(0) !== 16'h0011) begin failures++; $display("FAIL host_gated got %h exp 0011", acc_at(0)); end
        $display("restart: pc=%h M[3]=%h", first_addr, acc_at(0));
    endtask

    task automatic test_async_reset();
        clear_rom();
        rom[0] = ins(OP_LOAD, 1);
        rom[1] = ins(OP_ADD, 2);
        rom[2] = ins(OP_JMP, 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.acc !== 16'd8) begin failures++; $display("FAIL pre_reset_acc got %h exp 0008", bus.acc); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL async_busy got %b exp 0", bus.busy); end
        checks++; if (bus.retire !== 1'b0) begin failures++; $display("FAIL async_retire got %b exp 0", bus.retire); end
        checks++; if (bus.acc !== 16'h0000) begin failures++; $display("FAIL async_acc got %h exp 0000", bus.acc); end
        checks++; if (bus.imem_addr !== '0) begin failures++; $display("FAIL async_pc got %h exp 0", bus.imem_addr); end
        $display("async reset: busy=%b retire=%b acc=%h", bus.busy, bus.retire, bus.acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pc_wrap();
        bus2.host_we = 1'b1; bus2.host_addr = 3'd0; bus2.host_wdata = 16'h0001;
        @(negedge clk);
        bus2.host_addr = 3'd1; bus2.host_wdata = 16'h0010;
        @(negedge clk);
        bus2.host_we = 1'b0;
        for (int i = 0; i < 2**A2; i++) rom2[i] = {OP_JMP, 3'(i)};
        rom2[0] = {OP_ADD, 3'd0};
        rom2[1] = {OP_JMP, 3'd6};
        rom2[6] = {OP_ADD, 3'd1};
        rom2[7] = {OP_ADD, 3'd1};
        ret_cyc.delete();
        ret_acc.delete();
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (bus2.retire) begin
                ret_cyc.push_back(c);
                ret_acc.push_back(bus2.acc);
            end
            @(negedge clk);
        end
        bus2.stop = 1'b1;
        @(negedge clk);
        bus2.stop = 1'b0;
        checks++; if (cyc_at(4) !== 9) begin failures++; $display("FAIL wrap_cycle got %0d exp 9", cyc_at(4)); end
        checks++; if (acc_at(4) !== 16'h0022) begin failures++; $display("FAIL wrap_acc got %h exp 0022", acc_at(4)); end
        $display("pc wrap: retire cycle=%0d acc=%h", cyc_at(4), acc_at(4));
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;  bus.stop = 1'b0;  bus.host_we = 1'b0;
        bus.host_addr = '0; bus.host_wdata = '0;
        bus2.start = 1'b0; bus2.stop = 1'b0; bus2.host_we = 1'b0;
        bus2.host_addr = '0; bus2.host_wdata = '0;
        for (int i = 0; i < 2**A; i++) rom[i] = '0;
        for (int i = 0; i < 2**A2; i++) rom2[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        test_arith();
        test_forwarding();
        test_branch();
        test_stop_restart();
        test_async_reset();
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
